psdram_arbiter: RTL and testbench
=================================

PSDRAM_ARBITER -- requirements
Module: psdram_arbiter

Interface
REQ-001 Reset SHALL be `reset`, asynchronous, active-high; clock SHALL be `clk_25Mhz`.
REQ-002 Parameter ACCESS_CYCLES, default 3: cycles that CE and OE/WR are held asserted per access (min 2).
REQ-003 Parameter MAX_VID_BURST, default 8: maximum consecutive video grants while a host request is pending.
REQ-004 Ports (name  direction  width  meaning):
- clk_25Mhz  in  1  clock.
- reset  in  1  async reset.
- vid_req  in  1  video line-fetch read request, level.
- vid_addr  in  23  video word address.
- vid_ack  out  1  one-cycle pulse; vid_rdata valid.
- vid_rdata  out  16  video read data.
- host_req  in  1  host request, level.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  23  host word address.
- host_wdata  in  16  host write data.
- host_ack  out  1  one-cycle pulse: read data valid or write done.
- host_rdata  out  16  host read data.
- MemAdr  out  23  PSDRAM address.
- MemDataOut  out  16  write data driven to the pad.
- MemDataOE  out  1  pad output enable, active-high.
- MemDataIn  in  16  pad read data.
- RamCE, MemOE, MemWR, RamLB, RamUB  out  1 each  PSDRAM strobes, active-low.

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, RECOVER.
REQ-006 IDLE: if any request is asserted, latch the winner's address, we and wdata; assert RamCE=0, RamLB=0, RamUB=0, plus MemOE=0 (read) or MemWR=0 with MemDataOE=1 (write); go to ACCESS and load cnt=ACCESS_CYCLES-1. Otherwise stay in IDLE with all strobes high.
REQ-007 ACCESS: hold all strobes and the address stable and decrement cnt; when cnt==0, capture MemDataIn into the winner's rdata register (reads only), pulse that port's ack for exactly one cycle, deassert all strobes and MemDataOE, and go to RECOVER.
REQ-008 RECOVER: last exactly one cycle with RamCE=1, then return to IDLE. Back-to-back accesses are therefore ACCESS_CYCLES+2 cycles apart.
REQ-009 Latency: the ack SHALL occur ACCESS_CYCLES+1 cycles after the IDLE cycle in which the request was sampled.
REQ-010 Arbitration: video wins by fixed priority. Exception: when vid_streak==MAX_VID_BURST and host_req=1, the host wins.
REQ-011 vid_streak SHALL:
- increment on each video grant while host_req=1, saturating at MAX_VID_BURST;
- clear on a host grant, and whenever host_req=0 in IDLE.
REQ-012 Simultaneous vid_req and host_req with streak below the limit: video granted; host is served no later than after MAX_VID_BURST video accesses.
REQ-013 Requesters SHALL hold req, addr and wdata until their ack. The arbiter ignores input changes outside the IDLE sampling cycle.
REQ-014 A requester holding req after its ack is treated as a new request in the following IDLE cycle.
REQ-015 The rdata outputs SHALL hold their value until the next read for that port. Host writes SHALL NOT modify host_rdata.
REQ-016 MemDataOE SHALL never be 1 while MemOE=0. MemOE and MemWR SHALL never both be 0.
REQ-017 Address arithmetic is the requester's responsibility. The arbiter passes the 23-bit address unmodified.

Reset
REQ-018 On reset assertion, asynchronously:
- state=IDLE;
- RamCE, MemOE, MemWR, RamLB, RamUB = 1;
- MemDataOE=0; vid_ack=0, host_ack=0;
- MemAdr=0, MemDataOut=0; vid_rdata=0, host_rdata=0;
- vid_streak=0, cnt=0.
REQ-019 Reset mid-ACCESS SHALL abort the access with no ack, and no ack SHALL be issued after release. Operation resumes in the first IDLE cycle after deassertion.

Structure
REQ-020 State encodings, the PSDRAM address/data widths (23/16) and the strobe-inactive constant SHALL live in the shared package psdram_pkg.
REQ-021 The arbitration decision (fixed priority plus streak override) SHALL be a sub-module psdram_prio_sel. Counters and the FSM stay in psdram_arbiter.

Verification
REQ-022 Single video read at 0x000280, MemDataIn=0xA5C3 -> RamCE/MemOE low for 3 cycles; vid_ack at cycle 4 after sampling with vid_rdata=0xA5C3; RamCE high in RECOVER.
REQ-023 Host write addr=0x12345, data=0xBEEF -> MemWR low and MemDataOE high for 3 cycles with MemAdr=0x12345 and MemDataOut=0xBEEF; MemOE stays high; host_ack pulses once; host_rdata unchanged.
REQ-024 vid_req and host_req held continuously -> exactly 8 vid_acks, then 1 host_ack, repeating; accesses are 5 cycles apart.
REQ-025 Simultaneous first requests from both ports -> video granted first; host_ack 5 cycles after vid_ack.
REQ-026 Reset asserted in the second ACCESS cycle -> strobes go high immediately; no ack before or after release; a later host read completes normally.
REQ-027 Assertion monitor over all tests: REQ-016 invariants hold on every cycle, and no ack pulse is ever longer than 1 cycle.

Source files
------------

// File: rtl/psdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_pkg
//  Description : Shared types and constants for the PSDRAM arbiter slice:
//                FSM state encoding, pad address/data widths and the
//                inactive level of the active-low strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
package psdram_pkg;

    localparam int   C_ADDR_W     = 23;
    localparam int   C_DATA_W     = 16;
    localparam logic C_STROBE_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/psdram_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_prio_sel
//  Description : Grant decision between video and host. Video wins by fixed
//                priority unless its burst streak is exhausted while the host
//                is waiting, in which case the host is let through.
//  Revision    : 1.0 - initial release
// ============================================================================
module psdram_prio_sel (
    input  logic vid_req,
    input  logic host_req,
    input  logic streak_full,
    output logic grant_vid,
    output logic grant_host
);

    // Host wins when video is absent or has used up its burst allowance.
    assign grant_host = host_req & (~vid_req | streak_full);
    assign grant_vid  = vid_req & ~grant_host;

endmodule
`default_nettype wire

// File: rtl/psdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_arbiter
//  Description : Two-port (video read / host read-write) arbiter for an
//                asynchronous PSDRAM. Each access holds CE and OE/WR low for
//                ACCESS_CYCLES cycles followed by one recovery cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module psdram_arbiter
    import psdram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int MAX_VID_BURST = 8
) (
    input  logic                clk_25Mhz,
    input  logic                reset,
    input  logic                vid_req,
    input  logic [C_ADDR_W-1:0] vid_addr,
    output logic                vid_ack,
    output logic [C_DATA_W-1:0] vid_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [C_ADDR_W-1:0] host_addr,
    input  logic [C_DATA_W-1:0] host_wdata,
    output logic                host_ack,
    output logic [C_DATA_W-1:0] host_rdata,
    output logic [C_ADDR_W-1:0] MemAdr,
    output logic [C_DATA_W-1:0] MemDataOut,
    output logic                MemDataOE,
    input  logic [C_DATA_W-1:0] MemDataIn,
    output logic                RamCE,
    output logic                MemOE,
    output logic                MemWR,
    output logic                RamLB,
    output logic                RamUB
);

    localparam int CNT_W    = $clog2(ACCESS_CYCLES);
    localparam int STREAK_W = $clog2(MAX_VID_BURST + 1);

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [STREAK_W-1:0] r_streak, w_streak_nx;
    logic                r_win_host, w_win_host_nx;
    logic                r_we, w_we_nx;
    logic [C_ADDR_W-1:0] r_adr, w_adr_nx;
    logic [C_DATA_W-1:0] r_dout, w_dout_nx;
    logic                r_pad_oe, w_pad_oe_nx;
    logic                r_ce, r_oe, r_wr, r_lb, r_ub;
    logic                w_ce_nx, w_oe_nx, w_wr_nx, w_lb_nx, w_ub_nx;
    logic                r_vid_ack, w_vid_ack_nx, r_host_ack, w_host_ack_nx;
    logic [C_DATA_W-1:0] r_vid_rdata, w_vid_rdata_nx;
    logic [C_DATA_W-1:0] r_host_rdata, w_host_rdata_nx;
    logic                w_grant_vid, w_grant_host, w_streak_full;

    assign w_streak_full = (r_streak == STREAK_W'(MAX_VID_BURST));

    psdram_prio_sel u_prio_sel (
        .vid_req     (vid_req),
        .host_req    (host_req),
        .streak_full (w_streak_full),
        .grant_vid   (w_grant_vid),
        .grant_host  (w_grant_host)
    );

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_streak_nx     = r_streak;
        w_win_host_nx   = r_win_host;
        w_we_nx         = r_we;
        w_adr_nx        = r_adr;
        w_dout_nx       = r_dout;
        w_pad_oe_nx     = r_pad_oe;
        w_ce_nx         = r_ce;
        w_oe_nx         = r_oe;
        w_wr_nx         = r_wr;
        w_lb_nx         = r_lb;
        w_ub_nx         = r_ub;
        w_vid_ack_nx    = 1'b0;
        w_host_ack_nx   = 1'b0;
        w_vid_rdata_nx  = r_vid_rdata;
        w_host_rdata_nx = r_host_rdata;
        case (r_state)
            IDLE: begin
                // Streak only counts video grants made while the host waits.
                if (!host_req || w_grant_host) begin
                    w_streak_nx = '0;
                end else if (w_grant_vid && !w_streak_full) begin
                    w_streak_nx = r_streak + STREAK_W'(1);
                end
                if (w_grant_vid || w_grant_host) begin
                    w_state_nx    = ACCESS;
                    w_cnt_nx      = CNT_W'(ACCESS_CYCLES - 1);
                    w_win_host_nx = w_grant_host;
                    w_we_nx       = w_grant_host & host_we;
                    w_adr_nx      = w_grant_host ? host_addr : vid_addr;
                    w_ce_nx       = 1'b0;
                    w_lb_nx       = 1'b0;
                    w_ub_nx       = 1'b0;
                    if (w_grant_host && host_we) begin
                        w_dout_nx   = host_wdata;
                        w_wr_nx     = 1'b0;
                        w_pad_oe_nx = 1'b1;
                    end else begin
                        w_oe_nx = 1'b0;
                    end
                end else begin
                    w_ce_nx     = C_STROBE_OFF;
                    w_oe_nx     = C_STROBE_OFF;
                    w_wr_nx     = C_STROBE_OFF;
                    w_lb_nx     = C_STROBE_OFF;
                    w_ub_nx     = C_STROBE_OFF;
                    w_pad_oe_nx = 1'b0;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nx  = RECOVER;
                    w_ce_nx     = C_STROBE_OFF;
                    w_oe_nx     = C_STROBE_OFF;
                    w_wr_nx     = C_STROBE_OFF;
                    w_lb_nx     = C_STROBE_OFF;
                    w_ub_nx     = C_STROBE_OFF;
                    w_pad_oe_nx = 1'b0;
                    if (r_win_host) begin
                        w_host_ack_nx = 1'b1;
                        if (!r_we) begin
                            w_host_rdata_nx = MemDataIn;
                        end
                    end else begin
                        w_vid_ack_nx   = 1'b1;
                        w_vid_rdata_nx = MemDataIn;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and registered pad/port outputs; reset parks the bus idle.
    always_ff @(posedge clk_25Mhz or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_streak     <= '0;
            r_win_host   <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dout       <= '0;
            r_pad_oe     <= 1'b0;
            r_ce         <= C_STROBE_OFF;
            r_oe         <= C_STROBE_OFF;
            r_wr         <= C_STROBE_OFF;
            r_lb         <= C_STROBE_OFF;
            r_ub         <= C_STROBE_OFF;
            r_vid_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_vid_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_streak     <= w_streak_nx;
            r_win_host   <= w_win_host_nx;
            r_we         <= w_we_nx;
            r_adr        <= w_adr_nx;
            r_dout       <= w_dout_nx;
            r_pad_oe     <= w_pad_oe_nx;
            r_ce         <= w_ce_nx;
            r_oe         <= w_oe_nx;
            r_wr         <= w_wr_nx;
            r_lb         <= w_lb_nx;
            r_ub         <= w_ub_nx;
            r_vid_ack    <= w_vid_ack_nx;
            r_host_ack   <= w_host_ack_nx;
            r_vid_rdata  <= w_vid_rdata_nx;
            r_host_rdata <= w_host_rdata_nx;
        end
    end

    assign MemAdr     = r_adr;
    assign MemDataOut = r_dout;
    assign MemDataOE  = r_pad_oe;
    assign RamCE      = r_ce;
    assign MemOE      = r_oe;
    assign MemWR      = r_wr;
    assign RamLB      = r_lb;
    assign RamUB      = r_ub;
    assign vid_ack    = r_vid_ack;
    assign host_ack   = r_host_ack;
    assign vid_rdata  = r_vid_rdata;
    assign host_rdata = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_psdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psdram_arbiter
//  Description : Self-checking bench for psdram_arbiter. Expected acks are
//                queued when requests are raised and matched as acks appear;
//                a bus monitor watches the strobe invariants every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psdram_arbiter;

    logic        clk_25Mhz = 1'b0;
    logic        reset;
    logic        vid_req, host_req, host_we;
    logic [22:0] vid_addr, host_addr;
    logic [15:0] host_wdata;
    logic        vid_ack, host_ack;
    logic [15:0] vid_rdata, host_rdata;
    logic [22:0] MemAdr;
    logic [15:0] MemDataOut, MemDataIn;
    logic        MemDataOE, RamCE, MemOE, MemWR, RamLB, RamUB;

    logic        use_model;
    logic [15:0] mem_fixed;
    logic [15:0] exp_host_rdata;

    typedef struct {
        bit          host;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_mism = 0;

    // Memory model: read data is a fixed word or a function of the address.
    assign MemDataIn = use_model ? (MemAdr[15:0] ^ 16'h5A5A) : mem_fixed;

    always #20 clk_25Mhz = ~clk_25Mhz;

    psdram_arbiter #(.ACCESS_CYCLES(3), .MAX_VID_BURST(8)) dut (
        .clk_25Mhz  (clk_25Mhz),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rdata  (vid_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .MemAdr     (MemAdr),
        .MemDataOut (MemDataOut),
        .MemDataOE  (MemDataOE),
        .MemDataIn  (MemDataIn),
        .RamCE      (RamCE),
        .MemOE      (MemOE),
        .MemWR      (MemWR),
        .RamLB      (RamLB),
        .RamUB      (RamUB)
    );

    function automatic logic [15:0] model(input logic [22:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Scoreboard: every ack must match the oldest expected entry.
    exp_t sb_e;
    always @(negedge clk_25Mhz) begin
        if (!reset && (vid_ack || host_ack)) begin
            n_cmp++;
            if (vid_ack && host_ack) begin
                n_mism++;
                $display("FAIL sb_dual_ack: vid_ack=1 host_ack=1, required only one");
            end else if (exp_q.size() == 0) begin
                n_mism++;
                $display("FAIL sb_unexpected_ack: vid_ack=%0b host_ack=%0b, required none", vid_ack, host_ack);
            end else begin
                sb_e = exp_q.pop_front();
                if (sb_e.host != host_ack) begin
                    n_mism++;
                    $display("FAIL sb_port: host_ack=%0b, required host=%0b", host_ack, sb_e.host);
                end else if ((host_ack ? host_rdata : vid_rdata) !== sb_e.data) begin
                    n_mism++;
                    $display("FAIL sb_rdata: got %h, required %h", host_ack ? host_rdata : vid_rdata, sb_e.data);
                end
            end
        end
    end

    // Bus invariants and single-cycle ack pulses, checked every cycle.
    logic prev_vack = 1'b0, prev_hack = 1'b0;
    always @(negedge clk_25Mhz) begin
        if (MemDataOE && !MemOE) begin
            n_mism++;
            $display("FAIL mon_oe_conflict: MemDataOE=1 MemOE=0 at %0t", $time);
        end
        if (!MemOE && !MemWR) begin
            n_mism++;
            $display("FAIL mon_oe_wr: MemOE=0 MemWR=0 at %0t", $time);
        end
        if ((vid_ack && prev_vack) || (host_ack && prev_hack)) begin
            n_mism++;
            $display("FAIL mon_ack_width: ack high 2 cycles at %0t, required 1", $time);
        end
        prev_vack = vid_ack;
        prev_hack = host_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_25Mhz);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++;
        if ({RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, vid_ack, host_ack} !== 8'b11111000) begin
            n_mism++;
            $display("FAIL reset_strobes: got %b, required 11111000",
                     {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, vid_ack, host_ack});
        end
        n_cmp++;
        if (MemAdr !== 23'h0) begin
            n_mism++; $display("FAIL reset_adr: got %h, required 0", MemAdr);
        end
        n_cmp++;
        if (MemDataOut !== 16'h0) begin
            n_mism++; $display("FAIL reset_dout: got %h, required 0", MemDataOut);
        end
        n_cmp++;
        if (vid_rdata !== 16'h0 || host_rdata !== 16'h0) begin
            n_mism++; $display("FAIL reset_rdata: got %h/%h, required 0/0", vid_rdata, host_rdata);
        end
        reset = 1'b0;
        exp_host_rdata = 16'h0;
    endtask

    task automatic test_vid_read();
        repeat (2) tick();
        use_model = 1'b0;
        mem_fixed = 16'hA5C3;
        vid_addr  = 23'h000280;
        vid_req   = 1'b1;
        exp_q.push_back('{host: 1'b0, data: 16'hA5C3});
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, vid_ack} !== 7'b0010000 || MemAdr !== 23'h000280) begin
                n_mism++;
                $display("FAIL vid_access_c%0d: strobes %b adr %h, required 0010000 adr 000280", k,
                         {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, vid_ack}, MemAdr);
            end
        end
        tick();
        n_cmp++;
        if (vid_ack !== 1'b1 || RamCE !== 1'b1 || vid_rdata !== 16'hA5C3) begin
            n_mism++;
            $display("FAIL vid_ack_c4: ack=%b CE=%b rdata=%h, required 1 1 a5c3", vid_ack, RamCE, vid_rdata);
        end
        vid_req = 1'b0;
        tick();
    endtask

    task automatic test_host_write();
        repeat (2) tick();
        host_addr  = 23'h012345;
        host_wdata = 16'hBEEF;
        host_we    = 1'b1;
        host_req   = 1'b1;
        exp_q.push_back('{host: 1'b1, data: exp_host_rdata});
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++;
            if ({RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, host_ack} !== 7'b0100010 ||
                MemAdr !== 23'h012345 || MemDataOut !== 16'hBEEF) begin
                n_mism++;
                $display("FAIL host_wr_c%0d: strobes %b adr %h dout %h, required 0100010 012345 beef", k,
                         {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, host_ack}, MemAdr, MemDataOut);
            end
        end
        tick();
        n_cmp++;
        if (host_ack !== 1'b1 || MemWR !== 1'b1 || MemDataOE !== 1'b0 || host_rdata !== exp_host_rdata) begin
            n_mism++;
            $display("FAIL host_wr_ack: ack=%b WR=%b OE=%b rdata=%h, required 1 1 0 %h",
                     host_ack, MemWR, MemDataOE, host_rdata, exp_host_rdata);
        end
        host_req = 1'b0;
        host_we  = 1'b0;
        tick();
    endtask

    task automatic test_host_read(input logic [22:0] addr);
        int t_ack;
        repeat (2) tick();
        use_model = 1'b1;
        host_addr = addr;
        host_we   = 1'b0;
        host_req  = 1'b1;
        exp_q.push_back('{host: 1'b1, data: model(addr)});
        t_ack = -1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (host_ack) begin
                t_ack = t;
                break;
            end
        end
        host_req = 1'b0;
        exp_host_rdata = model(addr);
        n_cmp++;
        if (t_ack != 4) begin
            n_mism++;
            $display("FAIL host_rd_latency: ack at cycle %0d, required 4", t_ack);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int t_v, t_h;
        repeat (2) tick();
        use_model = 1'b1;
        vid_addr  = 23'h000155;
        host_addr = 23'h4000AA;
        host_we   = 1'b0;
        vid_req   = 1'b1;
        host_req  = 1'b1;
        exp_q.push_back('{host: 1'b0, data: model(23'h000155)});
        exp_q.push_back('{host: 1'b1, data: model(23'h4000AA)});
        t_v = -1;
        t_h = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (vid_ack) begin
                t_v = t;
                vid_req = 1'b0;
            end
            if (host_ack) begin
                t_h = t;
                break;
            end
        end
        vid_req  = 1'b0;
        host_req = 1'b0;
        exp_host_rdata = model(23'h4000AA);
        n_cmp++;
        if (t_v != 4) begin
            n_mism++; $display("FAIL simul_vid_first: vid_ack at %0d, required 4", t_v);
        end
        n_cmp++;
        if (t_h != 9) begin
            n_mism++; $display("FAIL simul_host_after: host_ack at %0d, required 9", t_h);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ack_t[18];
        bit ack_h[18];
        int n;
        repeat (2) tick();
        use_model = 1'b1;
        vid_addr  = 23'h0003C0;
        host_addr = 23'h7FFFFF;
        host_we   = 1'b0;
        vid_req   = 1'b1;
        host_req  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if ((i % 9) == 8) exp_q.push_back('{host: 1'b1, data: model(23'h7FFFFF)});
            else              exp_q.push_back('{host: 1'b0, data: model(23'h0003C0)});
        end
        n = 0;
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (vid_ack || host_ack) begin
                ack_t[n] = t;
                ack_h[n] = host_ack;
                n++;
                if (n == 18) break;
            end
        end
        vid_req  = 1'b0;
        host_req = 1'b0;
        exp_host_rdata = model(23'h7FFFFF);
        n_cmp++;
        if (n != 18) begin
            n_mism++; $display("FAIL b2b_count: %0d acks, required 18", n);
        end else begin
            n_cmp++;
            if (ack_t[0] != 4) begin
                n_mism++; $display("FAIL b2b_first: at %0d, required 4", ack_t[0]);
            end
            for (int i = 1; i < 18; i++) begin
                n_cmp++;
                if (ack_t[i] - ack_t[i-1] != 5 || ack_h[i] != ((i % 9) == 8)) begin
                    n_mism++;
                    $display("FAIL b2b_ack%0d: gap %0d host=%0b, required gap 5 host=%0b",
                             i, ack_t[i] - ack_t[i-1], ack_h[i], (i % 9) == 8);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int n_ack;
        repeat (2) tick();
        use_model = 1'b1;
        host_addr = 23'h002222;
        host_we   = 1'b0;
        host_req  = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (RamCE !== 1'b0 || MemOE !== 1'b0) begin
            n_mism++; $display("FAIL rst_mid_pre: CE=%b OE=%b, required 0 0", RamCE, MemOE);
        end
        reset    = 1'b1;
        host_req = 1'b0;
        #1;
        n_cmp++;
        if ({RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, host_ack} !== 7'b1111100) begin
            n_mism++;
            $display("FAIL rst_mid_strobes: got %b, required 1111100",
                     {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOE, host_ack});
        end
        repeat (2) tick();
        reset = 1'b0;
        exp_host_rdata = 16'h0;
        n_ack = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (vid_ack || host_ack) n_ack++;
        end
        n_cmp++;
        if (n_ack != 0 || host_rdata !== 16'h0) begin
            n_mism++;
            $display("FAIL rst_mid_noack: %0d acks rdata %h, required 0 acks rdata 0000", n_ack, host_rdata);
        end
        test_host_read(23'h001234);
    endtask

    initial begin
        reset      = 1'b1;
        vid_req    = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        vid_addr   = '0;
        host_addr  = '0;
        host_wdata = '0;
        use_model  = 1'b0;
        mem_fixed  = 16'h0;
        exp_host_rdata = 16'h0;

        test_reset();
        test_vid_read();
        test_host_write();
        test_host_read(23'h000ABC);
        test_host_write();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();

        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mism++; $display("FAIL sb_leftover: %0d expected acks never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
`default_nettype wire
